// File: rtl/id_exe_pipe_stage_if.sv
// Handshake and payload bundle between the ID stage, the ID/EXE register and the EXE stage.
// The master side is the pipeline environment (decoder, hazard unit, execute); the slave side is the stage.
interface id_exe_pipe_stage_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 256
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/id_exe_pipe_stage.sv
// ID->EXE pipeline register with valid/ready handshake, flush, control zeroing on bubbles,
// optional two-entry skid buffer (registered in_ready) and a saturating stall-cycle counter.
module id_exe_pipe_stage #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 256,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    id_exe_pipe_stage_if.slave bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_valid_r, main_valid_n;
    logic [CTRL_W-1:0] main_ctrl_r,  main_ctrl_n;
    logic [DATA_W-1:0] main_data_r,  main_data_n;
    logic              skid_valid_r, skid_valid_n;
    logic [CTRL_W-1:0] skid_ctrl_r,  skid_ctrl_n;
    logic [DATA_W-1:0] skid_data_r,  skid_data_n;
    logic              in_ready_r,   in_ready_n;
    logic [CNT_W-1:0]  stall_cnt_r,  stall_cnt_n;
    logic              in_ready_s;
    logic              accept_s;

    // Without a skid entry the ready path is combinational through out_ready.
    assign in_ready_s = (SKID != 0) ? in_ready_r : (!main_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = main_valid_r;
    assign bus.out_ctrl  = main_ctrl_r;
    assign bus.out_data  = main_data_r;
    assign occupancy     = {1'b0, main_valid_r} + {1'b0, skid_valid_r};
    assign stall_cnt     = stall_cnt_r;

    // Next-state for both entries; MAIN always holds the oldest item so ordering stays FIFO.
    always_comb begin
        main_valid_n = main_valid_r;
        main_ctrl_n  = main_ctrl_r;
        main_data_n  = main_data_r;
        skid_valid_n = skid_valid_r;
        skid_ctrl_n  = skid_ctrl_r;
        skid_data_n  = skid_data_r;
        if (bus.flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (main_valid_r && !bus.out_ready) begin
            // Held head: a new item can only be taken into the skid entry.
            if (accept_s) begin
                skid_valid_n = 1'b1;
                skid_ctrl_n  = bus.in_ctrl;
                skid_data_n  = bus.in_data;
            end else begin
                skid_valid_n = skid_valid_r;
            end
        end else if (skid_valid_r) begin
            main_valid_n = 1'b1;
            main_ctrl_n  = skid_ctrl_r;
            main_data_n  = skid_data_r;
            skid_valid_n = 1'b0;
        end else if (accept_s) begin
            main_valid_n = 1'b1;
            main_ctrl_n  = bus.in_ctrl;
            main_data_n  = bus.in_data;
        end else begin
            main_valid_n = 1'b0;
        end
        // A bubble must never carry write enables into EXE.
        if (!main_valid_n) begin
            main_ctrl_n = {CTRL_W{1'b0}};
        end else begin
            main_ctrl_n = main_ctrl_n;
        end
        in_ready_n = !skid_valid_n;
    end

    // Saturating count of cycles where EXE refuses a valid instruction.
    always_comb begin
        if (main_valid_r && !bus.out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_n = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_n = stall_cnt_r;
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            main_ctrl_r  <= {CTRL_W{1'b0}};
            main_data_r  <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= {CTRL_W{1'b0}};
            skid_data_r  <= {DATA_W{1'b0}};
            in_ready_r   <= 1'b1;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            main_valid_r <= main_valid_n;
            main_ctrl_r  <= main_ctrl_n;
            main_data_r  <= main_data_n;
            skid_valid_r <= skid_valid_n;
            skid_ctrl_r  <= skid_ctrl_n;
            skid_data_r  <= skid_data_n;
            in_ready_r   <= in_ready_n;
            stall_cnt_r  <= stall_cnt_n;
        end
    end
endmodule

// File: doc/id_exe_pipe_stage.md
Name: id_exe_pipe_stage

Overview:
- Parametrised successor to the fixed ID→EXE pipeline register.
- Carries a generic control bundle and a generic data bundle between decode and execute, under a valid/ready handshake.
- Adds flush (branch/jump squash), bubble insertion with control zeroing, an optional two-entry skid buffer that breaks the ready path, and a saturating stall-cycle counter.
- Sits between the ID stage and the EXE stage; the hazard unit drives flush and the downstream ready.

Parameters:
- CTRL_W, 16, width of control bundle (RegWrite, MemRead, MemWrite, ALUop, branch bits, ...).
- DATA_W, 256, width of data bundle (PC+4, register operands, immediate, register indices, func/shamt/fmt).
- SKID, 1, 0 = single register stage; 1 = two-entry skid buffer with registered in_ready.
- CNT_W, 16, width of stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bundle from decoder
- in_data  in  DATA_W  data bundle from ID
- flush  in  1  squash everything held and anything offered this cycle
- out_valid  out  1  EXE-side instruction valid
- out_ready  in  1  EXE accepts this cycle
- out_ctrl  out  CTRL_W  control to EXE; all-zero whenever out_valid=0
- out_data  out  DATA_W  data to EXE
- occupancy  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n=0, async, immediate):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1 once reset deasserts (SKID=1: in_ready is a register reset to 1).
  - Skid entry is invalidated.
- Transfer rules:
  - Accept on in_valid & in_ready.
  - Deliver on out_valid & out_ready.
  - All state updates on the rising edge of clk.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept: the main register loads in_ctrl/in_data and out_valid=1 next cycle. Latency is 1 cycle.
  - Deliver without accept: out_valid=0 next cycle.
- SKID=1:
  - Entries are MAIN (drives outputs) and SKID. in_ready = !skid_valid (registered).
  - Empty + accept → MAIN.
  - MAIN held (no deliver) + accept → SKID; in_ready=0 next cycle.
  - Deliver with SKID full → SKID moves to MAIN, in_ready=1 next cycle. An accept cannot occur in that cycle because in_ready=0.
  - Deliver + accept with only MAIN full → new item loads MAIN.
  - Ordering is strictly FIFO. Latency is 1 cycle when empty.
- Control zeroing: out_ctrl is forced to 0 whenever out_valid=0, so a bubble never writes registers or memory. out_data is don't-care but holds its last value.
- Flush:
  - Next edge: all entries invalid, out_valid=0, out_ctrl=0, occupancy=0.
  - An offered in_valid in the same cycle is dropped (flush wins), although in_ready may read 1.
  - Flush while out_valid & out_ready in the same cycle: the delivery counts as completed.
- Stall hold: while out_valid=1 & out_ready=0, out_ctrl and out_data are stable, bit-exact.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready, saturating at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.
- occupancy = valid entries after the edge; never exceeds 2 (SKID=1) or 1 (SKID=0).
- Reset mid-transfer: any held or partially accepted item is discarded; no output glitch beyond the asynchronous clear.

Test Plan:
- Streaming (SKID=1): in_valid=1 and out_ready=1 for 8 cycles, data 0..7 → out_data 0..7 in order, 1-cycle latency, occupancy=1 steady, stall_cnt=0.
- Backpressure: out_ready=0 while feeding A, B, C →
  - A on outputs, B held in SKID, in_ready=0 after B, C held upstream, occupancy=2.
  - Release out_ready → A, B, C delivered in order.
  - stall_cnt equals the number of held cycles (e.g. 3).
- Flush: occupancy=2, assert flush with in_valid=1 (data D) → next cycle out_valid=0, out_ctrl=0, occupancy=0, D never appears.
- Bubble: in_valid=0 for 2 cycles mid-stream with in_ctrl=16'hFFFF → out_valid=0 and out_ctrl=16'h0000 during both bubbles.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 → stall_cnt stops at 15.
- Async reset: drop rst_n mid-cycle with occupancy=2 → outputs clear immediately without waiting for clk; after release, in_ready=1 and occupancy=0. Repeat the streaming case with SKID=0 and check in_ready follows out_ready combinationally.
